// File: rtl/clk_div.sv
// Baud-rate generator: divides clk to BAUD*OVERSAMPLE ticks and BAUD-rate strobes, all outputs registered.
// One-cycle output latency; no backpressure, en freezes phase and clr restarts it.
module clk_div #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic clk_out,
  output logic tick,
  output logic baud_tick
);

  // Guard the divide below so a bad OVERSAMPLE reaches the explicit check instead of a div-by-zero.
  localparam int OS_SAFE = (OVERSAMPLE < 1) ? 1 : OVERSAMPLE;
  localparam int TICK_HZ = BAUD * OS_SAFE;
  localparam int DIV     = (CLK_FREQ + TICK_HZ / 2) / TICK_HZ;
  localparam int LOW     = DIV / 2;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW      = (OS_SAFE > 1) ? $clog2(OS_SAFE) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LOW = CW'(LOW);
  localparam logic [OW-1:0] OS_MAX  = OW'(OS_SAFE - 1);

  if (DIV < 2 || OVERSAMPLE < 1) begin : g_param_check
    $error("clk_div: DIV must be >= 2 and OVERSAMPLE >= 1");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [OW-1:0] os_cnt;
  logic          tick_ev;

  always_comb begin
    tick_ev = en && (cnt == CNT_MAX);
    cnt_nxt = cnt;
    if (en) begin
      cnt_nxt = tick_ev ? '0 : cnt + CW'(1);
    end
  end

  // rst and clr share the same restart state; rst only matters for priority, which is moot here.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt       <= '0;
      os_cnt    <= '0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      baud_tick <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      clk_out   <= (cnt_nxt >= CNT_LOW);
      tick      <= tick_ev;
      baud_tick <= tick_ev && (os_cnt == OS_MAX);
      if (tick_ev) begin
        os_cnt <= (os_cnt == OS_MAX) ? '0 : os_cnt + OW'(1);
      end
    end
  end

endmodule

// File: tb/tb_clk_div.sv
// Bench for clk_div: four parameter sets checked every cycle against a phase-count scoreboard.
module tb_clk_div;

  logic clk = 1'b0;
  logic rst, en, clr;
  logic clk_out_a, tick_a, baud_a;
  logic clk_out_b, tick_b, baud_b;
  logic clk_out_c, tick_c, baud_c;
  logic clk_out_d, tick_d, baud_d;

  always #5 clk = ~clk;

  // A: DIV=10, OS=16 with driven en/clr. B: DIV=7. C: defaults, DIV=326. D: DIV=10, OS=1.
  clk_div #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) u_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .clk_out(clk_out_a), .tick(tick_a), .baud_tick(baud_a));
  clk_div #(.CLK_FREQ(1_120_000), .BAUD(10_000), .OVERSAMPLE(16)) u_b (
    .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0),
    .clk_out(clk_out_b), .tick(tick_b), .baud_tick(baud_b));
  clk_div u_c (
    .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0),
    .clk_out(clk_out_c), .tick(tick_c), .baud_tick(baud_c));
  clk_div #(.CLK_FREQ(100_000), .BAUD(10_000), .OVERSAMPLE(1)) u_d (
    .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0),
    .clk_out(clk_out_d), .tick(tick_d), .baud_tick(baud_d));

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] c;
    logic [2:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   ph_a = 0, ph_b = 0, ph_c = 0, ph_d = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected {clk_out, tick, baud_tick} from the count of enabled cycles since the last restart.
  function automatic logic [2:0] model(input int ph, input int div, input int os, input bit adv);
    logic [2:0] r;
    r[2] = (ph % div) >= (div / 2);
    r[1] = adv && (ph % div == 0);
    r[0] = adv && (ph % (div * os) == 0);
    return r;
  endfunction

  task automatic drive(input logic r, input logic e, input logic c);
    exp_t ex;
    bit   adv_a;
    @(negedge clk);
    rst = r;
    en  = e;
    clr = c;
    adv_a = 1'b0;
    if (r) begin
      ph_a = 0; ph_b = 0; ph_c = 0; ph_d = 0;
    end else begin
      ph_b++; ph_c++; ph_d++;
      if (c) ph_a = 0;
      else if (e) begin
        ph_a++;
        adv_a = 1'b1;
      end
    end
    ex.a = model(ph_a, 10, 16, adv_a);
    ex.b = model(ph_b, 7, 16, !r);
    ex.c = model(ph_c, 326, 16, !r);
    ex.d = model(ph_d, 10, 1, !r);
    sb.push_back(ex);
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    chk("a_clk_out",   32'(clk_out_a), 32'(ex.a[2]));
    chk("a_tick",      32'(tick_a),    32'(ex.a[1]));
    chk("a_baud_tick", 32'(baud_a),    32'(ex.a[0]));
    chk("b_clk_out",   32'(clk_out_b), 32'(ex.b[2]));
    chk("b_tick",      32'(tick_b),    32'(ex.b[1]));
    chk("b_baud_tick", 32'(baud_b),    32'(ex.b[0]));
    chk("c_clk_out",   32'(clk_out_c), 32'(ex.c[2]));
    chk("c_tick",      32'(tick_c),    32'(ex.c[1]));
    chk("c_baud_tick", 32'(baud_c),    32'(ex.c[0]));
    chk("d_clk_out",   32'(clk_out_d), 32'(ex.d[2]));
    chk("d_tick",      32'(tick_d),    32'(ex.d[1]));
    chk("d_baud_tick", 32'(baud_d),    32'(ex.d[0]));
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    repeat (2) drive(1'b1, 1'b0, 1'b0);
    // Free run past two baud periods of A.
    repeat (403) drive(1'b0, 1'b1, 1'b0);
    // Hold mid-period for 13 cycles.
    repeat (13) drive(1'b0, 1'b0, 1'b0);
    repeat (60) drive(1'b0, 1'b1, 1'b0);
    // Restart phase at cnt=6.
    while (ph_a % 10 != 6) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    repeat (200) drive(1'b0, 1'b1, 1'b0);
    // clr must win even with en low.
    repeat (3) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    repeat (30) drive(1'b0, 1'b1, 1'b0);
    // Reset at cnt=8 for one cycle, with en and clr both asserted to exercise priority.
    while (ph_a % 10 != 8) drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    repeat (40) drive(1'b0, 1'b1, 1'b0);
    repeat (300) drive(1'b0, ($urandom_range(0, 3) != 0), 1'b0);
    // Long run to see two full default-parameter baud periods.
    repeat (10700) drive(1'b0, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
